// File: rtl/sensor_pkg.sv
// Shared types for the sensor acquisition path: sample width, sample type
// and the SPI acquisition FSM states.
package sensor_pkg;
  localparam int SENSOR_DATA_W = 16;

  typedef logic [SENSOR_DATA_W-1:0] sensor_sample_t;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} acq_state_t;
endpackage

// File: rtl/sensor_tick_gen.sv
// Free-running period timer: one-cycle tick every SAMPLE_PERIOD cycles while
// enable is high, held at zero while enable is low.
module sensor_tick_gen #(
  parameter int SAMPLE_PERIOD = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);
  localparam int CNT_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = 1'b0;
    cnt_d = cnt_q + CNT_W'(1);
    if (!enable) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      tick  = 1'b1;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/sensor_acq_spi.sv
// Periodic SPI mode-0 ADC reader: one DATA_W-bit MSB-first conversion per tick,
// presented as sensor_data with a one-cycle data_valid strobe.
module sensor_acq_spi
  import sensor_pkg::*;
#(
  parameter int DATA_W        = SENSOR_DATA_W,
  parameter int CLK_DIV       = 4,
  parameter int CS_SETUP      = 2,
  parameter int SAMPLE_PERIOD = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              overrun_clr,
  input  logic              spi_miso,
  output logic              spi_sclk,
  output logic              spi_cs_n,
  output logic [DATA_W-1:0] sensor_data,
  output logic              data_valid,
  output logic              busy,
  output logic              overrun
);
  localparam int CW    = 16;
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [CW-1:0]    SETUP_LAST = (CS_SETUP > 0) ? CW'(CS_SETUP - 1) : '0;
  localparam logic [CW-1:0]    DIV_LAST   = CW'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_W - 1);

  logic tick;

  sensor_tick_gen #(
    .SAMPLE_PERIOD(SAMPLE_PERIOD)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .enable(enable),
    .tick  (tick)
  );

  acq_state_t        state_q;
  logic [CW-1:0]     cnt_q;
  logic [BIT_W-1:0]  bit_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] data_q;
  logic              sclk_q, cs_n_q, busy_q, dv_q, ovr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      dv_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      dv_q <= 1'b0;
      // A tick that finds the converter busy is dropped; setting beats clearing.
      if (tick && busy_q)   ovr_q <= 1'b1;
      else if (overrun_clr) ovr_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (tick) begin
            cs_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            sclk_q  <= 1'b0;
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= (CS_SETUP == 0) ? SHIFT : SETUP;
          end
        end
        SETUP: begin
          if (cnt_q == SETUP_LAST) begin
            cnt_q   <= '0;
            state_q <= SHIFT;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        SHIFT: begin
          if (cnt_q == DIV_LAST) begin
            cnt_q <= '0;
            if (!sclk_q) begin
              sclk_q  <= 1'b1;
              shift_q <= {shift_q[DATA_W-2:0], spi_miso};
            end else begin
              sclk_q <= 1'b0;
              if (bit_q == BIT_LAST) begin
                state_q <= DONE;
                cs_n_q  <= 1'b1;
                data_q  <= shift_q;
                dv_q    <= 1'b1;
              end else begin
                bit_q <= bit_q + BIT_W'(1);
              end
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign spi_sclk    = sclk_q;
  assign spi_cs_n    = cs_n_q;
  assign sensor_data = data_q;
  assign data_valid  = dv_q;
  assign busy        = busy_q;
  assign overrun     = ovr_q;
endmodule

// File: doc/sensor_acq_spi.md
Name: sensor_acq_spi

Overview:
Upstream acquisition stage for the sensor processing block. It periodically reads one 16-bit sample from an external SPI ADC using mode 0 (CPOL=0, CPHA=0), MSB first. It presents each sample as sensor_data with a one-cycle data_valid strobe. These two outputs connect directly to the sensor processing block's inputs. There is no backpressure; the consumer must accept every strobe.

Parameters:
DATA_W, 16, sample width and number of SPI bits per conversion.
CLK_DIV, 4, clk cycles per sclk half-period; legal range is 1 or more.
CS_SETUP, 2, clk cycles from cs_n falling to the first sclk rising half-period.
SAMPLE_PERIOD, 1000, clk cycles between conversion ticks; must be 2 or more.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
rst  in  1  reset; asynchronous and active-high.
enable  in  1  high = periodic acquisition runs.
overrun_clr  in  1  one-cycle pulse that clears overrun.
spi_miso  in  1  ADC serial data.
spi_sclk  out  1  SPI clock; idles low.
spi_cs_n  out  1  ADC chip select; active-low, idles high.
sensor_data  out  DATA_W  last completed sample; held between strobes.
data_valid  out  1  one-cycle strobe marking a new sensor_data.
busy  out  1  high from the tick until the cycle after data_valid.
overrun  out  1  sticky flag: a tick arrived while busy.

Behaviour:
- Reset values (applied asynchronously while rst=1): spi_sclk=0, spi_cs_n=1, sensor_data=0, data_valid=0, busy=0, overrun=0, FSM=IDLE, period counter=0, shift register=0.
- Reset mid-conversion aborts immediately: cs_n goes high and sclk goes low with no clock edge. No data_valid is produced for the aborted read.
- Period timer:
  - While enable=1, the counter increments.
  - When counter=SAMPLE_PERIOD-1, tick=1 and the counter wraps to 0.
  - While enable=0, the counter is held at 0.
  - Result: the first tick comes SAMPLE_PERIOD cycles after enable rises.
- FSM states: IDLE, SETUP, SHIFT, DONE.
  - IDLE: on tick, go to SETUP. cs_n=0 and busy=1 from the next cycle.
  - SETUP: hold for CS_SETUP cycles with sclk=0, then go to SHIFT.
  - SHIFT: DATA_W bit periods, each 2*CLK_DIV cycles long.
    - sclk is low for the first CLK_DIV cycles of each bit period and high for the second CLK_DIV cycles.
    - On the clk edge that drives sclk 0->1, spi_miso is shifted into the LSB of the shift register.
    - After the last high half-period, sclk=0 and the FSM goes to DONE.
  - DONE (one cycle):
    - cs_n=1.
    - sensor_data<=shift register.
    - data_valid=1 in the same cycle sensor_data changes.
    - Next state is IDLE, with busy=0 in the following cycle.
- Latency: data_valid is asserted exactly CS_SETUP + 2*DATA_W*CLK_DIV + 1 cycles after the tick cycle. With defaults this is 2+128+1 = 131 cycles.
- Overrun:
  - A tick while busy=1 is dropped and overrun<=1.
  - overrun_clr clears the flag.
  - If a new overrun and overrun_clr occur in the same cycle, set wins.
- enable falling mid-conversion: the current conversion completes normally and emits data_valid. No further ticks occur.
- A tick in the DONE cycle counts as busy: it is dropped and sets overrun.
- spi_miso is sampled directly with no synchronizer. The board guarantees the ADC output is synchronous to clk.
- data_valid is never high for two consecutive cycles.

Decomposition:
- Shared package sensor_pkg:
  - SENSOR_DATA_W=16.
  - typedef sensor_sample_t for the 16-bit sample type.
  - enum acq_state_t {IDLE, SETUP, SHIFT, DONE}.
- One sub-module, sensor_tick_gen: the period counter.
  - Inputs: clk, rst, enable.
  - Output: tick.
  - Parameter: SAMPLE_PERIOD.
  - The sensor processing block's future decimation timer reuses it.

Test Plan:
1. Defaults, enable=1, ADC model shifts 0x0020 -> first tick at cycle 1000 after enable; cs_n falls at +1; 16 sclk pulses of 8-cycle period; sensor_data=0x0020 with a one-cycle data_valid at tick+131; cs_n=1 in the same cycle.
2. ADC model returns 0x0000, then 0xFFFF, then 0x0080 on three consecutive ticks -> three strobes exactly 1000 cycles apart; sensor_data=0x0000, 0xFFFF, 0x0080 in order; overrun=0 throughout.
3. SAMPLE_PERIOD=100, CLK_DIV=4 -> a tick lands while busy; overrun=1 and that conversion is skipped; pulse overrun_clr -> overrun=0; an overrun_clr coincident with a new overrun leaves overrun=1.
4. Assert rst for 3 cycles during SHIFT, after 5 bits -> cs_n=1 and sclk=0 asynchronously; no data_valid; sensor_data keeps its reset value 0; after release with enable=1, the next tick comes 1000 cycles later.
5. Drop enable during SHIFT of a 0x0050 read -> data_valid still fires with 0x0050; no further cs_n activity for 3000 cycles.
6. CLK_DIV=1, CS_SETUP=0, data 0xA5A5 -> sclk toggles every cycle; data_valid at tick+33 with sensor_data=0xA5A5.
